// File: rtl/reflet_float_to_int_seq_pkg.sv
// rtl/reflet_float_to_int_seq_pkg.sv - shared float field widths, FSM/case encodings and saturation helper
package reflet_float_to_int_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLASSIFY,
        ST_SHIFT,
        ST_SIGN,
        ST_DONE
    } f2i_state_e;

    typedef enum logic [1:0] {
        CASE_ZERO,
        CASE_SAT,
        CASE_NORMAL
    } f2i_case_e;

    function automatic int exponent_size(input int float_size);
        if (float_size == 16) return 5;
        else if (float_size == 64) return 11;
        else return 8;
    endfunction

    function automatic int mantissa_size(input int float_size);
        return float_size - exponent_size(float_size) - 1;
    endfunction

    function automatic int exponent_biais(input int float_size);
        return (1 << (exponent_size(float_size) - 1)) - 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Two's-complement saturation limit for an int_size-bit integer; callers keep the low int_size bits.
    function automatic logic [63:0] sat_value(input int int_size, input logic sign);
        if (sign) return ~((64'd1 << (int_size - 1)) - 64'd1);
        else return (64'd1 << (int_size - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/reflet_float_classify.sv
// rtl/reflet_float_classify.sv - combinational decode of a float into case code, shift distance and special result
module reflet_float_classify
    import reflet_float_to_int_seq_pkg::*;
#(
    parameter int float_size = 32,
    parameter int int_size   = 16
) (
    input  logic [float_size-1:0] float_in,
    output f2i_case_e             case_code,
    output logic signed [31:0]    d,
    output logic [int_size-1:0]   special_result,
    output logic                  special_overflow
);

    localparam int E = exponent_size(float_size);
    localparam int M = mantissa_size(float_size);
    localparam int B = exponent_biais(float_size);

    localparam logic [63:0] sat_pos_full = sat_value(int_size, 1'b0);
    localparam logic [63:0] sat_neg_full = sat_value(int_size, 1'b1);
    localparam logic [int_size-1:0] sat_pos = sat_pos_full[int_size-1:0];
    localparam logic [int_size-1:0] sat_neg = sat_neg_full[int_size-1:0];

    logic                sign;
    logic [E-1:0]        exp;
    logic [M-1:0]        man;
    logic signed [31:0]  e;
    logic [int_size-1:0] sat_by_sign;

    assign sign        = float_in[float_size-1];
    assign exp         = float_in[float_size-2 -: E];
    assign man         = float_in[M-1:0];
    assign e           = $signed(32'(exp)) - B;
    assign d           = e - M;
    assign sat_by_sign = sign ? sat_neg : sat_pos;

    always_comb begin
        case_code        = CASE_NORMAL;
        special_result   = '0;
        special_overflow = 1'b0;
        if (exp == '1) begin
            case_code        = CASE_SAT;
            special_overflow = 1'b1;
            special_result   = (man != '0) ? sat_pos : sat_by_sign;
        end else if (exp == '0 || e < 0) begin
            case_code = CASE_ZERO;
        end else if (e > int_size - 1) begin
            case_code        = CASE_SAT;
            special_overflow = 1'b1;
            special_result   = sat_by_sign;
        end else if (e == int_size - 1) begin
            // Only exactly -2^(int_size-1) fits at this exponent; anything else saturates.
            case_code = CASE_SAT;
            if (sign && man == '0) begin
                special_result = sat_neg;
            end else begin
                special_result   = sat_by_sign;
                special_overflow = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reflet_float_to_int_seq.sv
// rtl/reflet_float_to_int_seq.sv - multi-cycle float to signed int converter; REFLET_F2I_BARREL_EN selects a one-cycle barrel shift
module reflet_float_to_int_seq
    import reflet_float_to_int_seq_pkg::*;
#(
    parameter int float_size = 32,
    parameter int int_size   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [float_size-1:0] float_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [int_size-1:0]   int_out,
    output logic                  overflow
);

    localparam int M  = mantissa_size(float_size);
    localparam int W  = max_int(M + 1, int_size);
    localparam int CW = $clog2(W + 1);

    f2i_state_e              state;
    logic [float_size-1:0]   float_reg;
    logic [W-1:0]            work;
    logic [CW-1:0]           count;
    logic                    shift_left;

    f2i_case_e               case_code;
    logic signed [31:0]      d;
    logic signed [31:0]      abs_d;
    logic [int_size-1:0]     special_result;
    logic                    special_overflow;
    logic [int_size-1:0]     mag;

    reflet_float_classify #(
        .float_size(float_size),
        .int_size  (int_size)
    ) u_classify (
        .float_in        (float_reg),
        .case_code       (case_code),
        .d               (d),
        .special_result  (special_result),
        .special_overflow(special_overflow)
    );

    assign in_ready = (state == ST_IDLE);
    assign abs_d    = (d < 0) ? -d : d;
    assign mag      = work[int_size-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            float_reg  <= '0;
            work       <= '0;
            count      <= '0;
            shift_left <= 1'b0;
            out_valid  <= 1'b0;
            int_out    <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        float_reg <= float_in;
                        state     <= ST_CLASSIFY;
                    end
                end
                ST_CLASSIFY: begin
                    if (case_code != CASE_NORMAL) begin
                        int_out   <= special_result;
                        overflow  <= special_overflow;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        work       <= W'({1'b1, float_reg[M-1:0]});
                        count      <= CW'(abs_d);
                        shift_left <= (d > 0);
`ifdef REFLET_F2I_BARREL_EN
                        state      <= ST_SHIFT;
`else
                        state      <= (d != 0) ? ST_SHIFT : ST_SIGN;
`endif
                    end
                end
                ST_SHIFT: begin
`ifdef REFLET_F2I_BARREL_EN
                    work  <= shift_left ? (work << count) : (work >> count);
                    state <= ST_SIGN;
`else
                    work  <= shift_left ? (work << 1) : (work >> 1);
                    count <= count - 1'b1;
                    if (count == CW'(1)) state <= ST_SIGN;
`endif
                end
                ST_SIGN: begin
                    int_out   <= float_reg[float_size-1] ? -mag : mag;
                    overflow  <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
